// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared config type and reset value for the PWM compare stage
package pwm_pkg;

  localparam int PWM_CNT_BITS = 4;

  typedef struct packed {
    logic [PWM_CNT_BITS-1:0] duty;
    logic                    pol;
  } pwm_cfg_t;

  localparam pwm_cfg_t PWM_CFG_RST = '{duty: '0, pol: 1'b0};

endpackage

// File: rtl/pwm_compare.sv
// rtl/pwm_compare.sv - PWM compare stage with period-boundary config swap
// Config lands in a shadow register and moves to active only on a wrap or while stopped.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int NUM_CNT_BITS = PWM_CNT_BITS
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    run,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] count_out,
  input  logic                    rollover_flag,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [NUM_CNT_BITS-1:0] cfg_duty,
  input  logic                    cfg_polarity,
  output logic                    cnt_clear,
  output logic                    pwm_out,
  output logic                    period_done,
  output logic                    cfg_applied
);

  pwm_cfg_t shadow_cfg;
  pwm_cfg_t active_cfg;
  logic     pending;
  logic     boundary;
  logic     apply_edge;
  logic     accept;
  logic     in_high;

  assign cnt_clear  = ~run;
  assign cfg_ready  = ~pending;
  assign accept     = cfg_valid & ~pending;
  assign boundary   = run & count_enable & rollover_flag;
  assign apply_edge = boundary | ~run;
  assign in_high    = run & (count_out != '0) & (count_out <= active_cfg.duty);

  // accept needs pending=0 and apply needs pending=1, so an offer taken on a
  // boundary edge is only stored and waits for the following boundary
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow_cfg  <= PWM_CFG_RST;
      active_cfg  <= PWM_CFG_RST;
      pending     <= 1'b0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;
      period_done <= boundary;
      pwm_out     <= active_cfg.pol ^ in_high;
      if (apply_edge && pending) begin
        active_cfg  <= shadow_cfg;
        pending     <= 1'b0;
        cfg_applied <= 1'b1;
      end
      if (accept) begin
        shadow_cfg <= '{duty: cfg_duty, pol: cfg_polarity};
        pending    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_compare.sv
// tb/tb_pwm_compare.sv - scoreboard bench for pwm_compare driven by a period counter model
module tb_pwm_compare;

  localparam int N = 4;
  localparam logic [N-1:0] ROLL = 4'd10;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         run;
  logic         count_enable;
  logic [N-1:0] count_out;
  logic         rollover_flag;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] cfg_duty;
  logic         cfg_polarity;
  logic         cnt_clear;
  logic         pwm_out;
  logic         period_done;
  logic         cfg_applied;

  int n_checks = 0;
  int n_fail   = 0;

  // {pwm_out, period_done, cfg_applied, cfg_ready}
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  logic [3:0] last_obs;
  logic [3:0] e_item;
  logic [3:0] o_item;

  logic [N-1:0] m_sh_duty, m_act_duty;
  logic         m_sh_pol, m_act_pol, m_pend;

  pwm_compare #(.NUM_CNT_BITS(N)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .run          (run),
    .count_enable (count_enable),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_duty     (cfg_duty),
    .cfg_polarity (cfg_polarity),
    .cnt_clear    (cnt_clear),
    .pwm_out      (pwm_out),
    .period_done  (period_done),
    .cfg_applied  (cfg_applied)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    m_sh_duty  = '0;
    m_sh_pol   = 1'b0;
    m_act_duty = '0;
    m_act_pol  = 1'b0;
    m_pend     = 1'b0;
    count_out  = '0;
    rollover_flag = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic step();
    logic acc, bnd, ap, pw;
    acc = cfg_valid && !m_pend;
    bnd = run && count_enable && rollover_flag;
    ap  = (bnd || !run) && m_pend;
    pw  = m_act_pol ^ (run && (count_out != 0) && (count_out <= m_act_duty));
    if (ap) begin
      m_act_duty = m_sh_duty;
      m_act_pol  = m_sh_pol;
      m_pend     = 1'b0;
    end
    if (acc) begin
      m_sh_duty = cfg_duty;
      m_sh_pol  = cfg_polarity;
      m_pend    = 1'b1;
    end
    exp_q.push_back({pw, bnd, ap, !m_pend});
    @(posedge clk);
    #1;
    last_obs = {pwm_out, period_done, cfg_applied, cfg_ready};
    obs_q.push_back(last_obs);
    if (acc) cfg_valid = 1'b0;
    if (!run) count_out = '0;
    else if (count_enable) count_out = (count_out == ROLL) ? 4'd1 : N'(count_out + 4'd1);
    rollover_flag = (count_out == ROLL);
  endtask

  task automatic push_cfg(input logic [N-1:0] d, input logic p);
    cfg_duty     = d;
    cfg_polarity = p;
    cfg_valid    = 1'b1;
    step();
  endtask

  task automatic sync_to_count(input logic [N-1:0] k);
    int guard;
    guard = 0;
    while (count_out != k && guard < 40) begin
      step();
      guard++;
    end
    if (count_out != k) begin
      n_checks++;
      n_fail++;
      $display("FAIL sync_to_count: count_out=%0d required %0d", count_out, k);
    end
  endtask

  task automatic run_count(input int ncyc, output int highs, output int dones);
    highs = 0;
    dones = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (last_obs[3]) highs++;
      if (last_obs[2]) dones++;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; run = 1'b0; count_enable = 1'b1; cfg_valid = 1'b0;
    cfg_duty = '0; cfg_polarity = 1'b0;
    reset_model();
    #3;
    n_checks++;
    if ({pwm_out, period_done, cfg_applied, cfg_ready, cnt_clear} !== 5'b00011) begin
      n_fail++;
      $display("FAIL reset_initial: outputs=%b required 00011",
               {pwm_out, period_done, cfg_applied, cfg_ready, cnt_clear});
    end
    @(negedge clk);
    n_rst = 1'b1;
    push_cfg(4'd10, 1'b0);
    step();
    run = 1'b1;
    sync_to_count(4'd3);
    push_cfg(4'd2, 1'b0);
    step();
    n_checks++;
    if (pwm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun_pwm: pwm_out=%b required 1", pwm_out);
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL reset_scoreboard: got %b required %b", o_item, e_item);
      end
    end
    #2;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({pwm_out, cfg_ready, period_done, cfg_applied} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_midrun: {pwm,ready,done,applied}=%b required 0100",
               {pwm_out, cfg_ready, period_done, cfg_applied});
    end
    run = 1'b0;
    reset_model();
    @(negedge clk);
    n_rst = 1'b1;
    step();
    step();
    n_checks++;
    if (cfg_applied !== 1'b0 || pwm_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: cfg_applied=%b pwm_out=%b required 0 0", cfg_applied, pwm_out);
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL reset_post_scoreboard: got %b required %b", o_item, e_item);
      end
    end
  endtask

  task automatic test_basic_waveform();
    int hi, pd;
    run = 1'b0;
    push_cfg(4'd3, 1'b0);
    step();
    run = 1'b1;
    sync_to_count(4'd1);
    n_checks++;
    if (cnt_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_cnt_clear: cnt_clear=%b required 0", cnt_clear);
    end
    run_count(20, hi, pd);
    n_checks++;
    if (hi != 6 || pd != 2) begin
      n_fail++;
      $display("FAIL basic_waveform: highs=%0d dones=%0d required 6 2", hi, pd);
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL basic_scoreboard: got %b required %b", o_item, e_item);
      end
    end
  endtask

  task automatic test_midperiod_update();
    int hi, pd, guard;
    sync_to_count(4'd5);
    push_cfg(4'd7, 1'b0);
    n_checks++;
    if (last_obs[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL update_ready_low: cfg_ready=%b required 0", last_obs[0]);
    end
    hi = 0; guard = 0;
    do begin
      step();
      if (last_obs[3]) hi++;
      guard++;
    end while (!last_obs[2] && guard < 15);
    n_checks++;
    if (!last_obs[2] || guard != 5 || hi != 0) begin
      n_fail++;
      $display("FAIL update_old_duty: done=%b cycles=%0d highs=%0d required 1 5 0", last_obs[2], guard, hi);
    end
    n_checks++;
    if (last_obs[1] !== 1'b1 || last_obs[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL update_applied: cfg_applied=%b cfg_ready=%b required 1 1", last_obs[1], last_obs[0]);
    end
    run_count(10, hi, pd);
    n_checks++;
    if (hi != 7) begin
      n_fail++;
      $display("FAIL update_new_duty: highs=%0d required 7", hi);
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL update_scoreboard: got %b required %b", o_item, e_item);
      end
    end
  endtask

  task automatic test_duty_extremes();
    logic [N-1:0] d_tab[5]  = '{4'd0, 4'd15, 4'd0, 4'd15, 4'd3};
    logic         p_tab[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int           hi_tab[5] = '{0, 10, 10, 0, 7};
    int hi, pd;
    for (int i = 0; i < 5; i++) begin
      run = 1'b0;
      push_cfg(d_tab[i], p_tab[i]);
      step();
      run = 1'b1;
      sync_to_count(4'd1);
      run_count(10, hi, pd);
      n_checks++;
      if (hi != hi_tab[i]) begin
        n_fail++;
        $display("FAIL extremes_row%0d: highs=%0d required %0d", i, hi, hi_tab[i]);
      end
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL extremes_scoreboard: got %b required %b", o_item, e_item);
      end
    end
  endtask

  task automatic test_boundary_handshake();
    int guard;
    sync_to_count(ROLL);
    push_cfg(4'd5, 1'b0);
    n_checks++;
    if (last_obs[2:0] !== 3'b100) begin
      n_fail++;
      $display("FAIL boundary_store_only: {done,applied,ready}=%b required 100", last_obs[2:0]);
    end
    guard = 0;
    do begin
      step();
      guard++;
    end while (!last_obs[1] && guard < 20);
    n_checks++;
    if (!last_obs[1] || guard != 10 || !last_obs[2]) begin
      n_fail++;
      $display("FAIL boundary_next_wrap: applied=%b cycles=%0d done=%b required 1 10 1", last_obs[1], guard, last_obs[2]);
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL boundary_scoreboard: got %b required %b", o_item, e_item);
      end
    end
  endtask

  task automatic test_enable_hold();
    int hi, pd, events;
    sync_to_count(ROLL);
    count_enable = 1'b0;
    push_cfg(4'd9, 1'b0);
    events = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (last_obs[2] || last_obs[1]) events++;
    end
    n_checks++;
    if (events != 0 || last_obs[2:1] !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_no_boundary: events=%0d required 0", events);
    end
    count_enable = 1'b1;
    step();
    n_checks++;
    if (last_obs[2:1] !== 2'b11) begin
      n_fail++;
      $display("FAIL hold_release_swap: {done,applied}=%b required 11", last_obs[2:1]);
    end
    run_count(10, hi, pd);
    n_checks++;
    if (hi != 9 || pd != 1) begin
      n_fail++;
      $display("FAIL hold_new_duty: highs=%0d dones=%0d required 9 1", hi, pd);
    end
    while (exp_q.size() > 0) begin
      e_item = exp_q.pop_front(); o_item = obs_q.pop_front(); n_checks++;
      if (o_item !== e_item) begin
        n_fail++;
        $display("FAIL hold_scoreboard: got %b required %b", o_item, e_item);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_waveform();
    test_midperiod_update();
    test_duty_extremes();
    test_boundary_handshake();
    test_enable_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
